// File: rtl/fifo_pkg.sv
// Shared FIFO constants and gray-code helpers used by both pointer domains.
package fifo_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEF_ADDR_W  = 4;

  // Prefix-XOR from the MSB down; callers zero-extend narrower pointers.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-gray converter.
module bin_to_gray #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-side pointer and full/almost-full/overflow flag generation for an async FIFO.
// Define FIFO_ALMOST_FULL_EN to build the almost_full occupancy comparator.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned AF_LEVEL = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wr_en,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic              overflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] gray_next;
  logic [PTR_W-1:0] rq1;
  logic [PTR_W-1:0] rq2;
  logic [PTR_W-1:0] full_ptr;
  logic             unused_cfg;

  assign unused_cfg = ^{32'(AF_LEVEL), 32'(SYNC_STAGES)};

  assign wr_en     = push & ~full & ~rst;
  assign wbin_next = wbin + PTR_W'(wr_en);
  assign waddr     = wbin[ADDR_W-1:0];

  // Write pointer that has lapped the synchronized read pointer exactly once.
  assign full_ptr = {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]};

  bin_to_gray #(
    .WIDTH (PTR_W)
  ) u_bin_to_gray (
    .bin  (wbin_next),
    .gray (gray_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin      <= '0;
      wptr_gray <= '0;
      rq1       <= '0;
      rq2       <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rq1       <= rptr_gray_async;
      rq2       <= rq1;
      wbin      <= wbin_next;
      wptr_gray <= gray_next;
      full      <= (gray_next == full_ptr);
      overflow  <= push & full;
    end
  end

`ifdef FIFO_ALMOST_FULL_EN
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] occupancy;
  logic             af_next;

  // Occupancy against the synchronized (stale) read pointer is pessimistic.
  assign rbin      = PTR_W'(gray2bin(32'(rq2)));
  assign occupancy = wbin_next - rbin;
  assign af_next   = (32'(occupancy) >= AF_LEVEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full <= 1'b0;
    end else begin
      almost_full <= af_next;
    end
  end
`else
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Directed scoreboard bench for fifo_wptr_ctrl at ADDR_W=2.
module tb_fifo_wptr_ctrl;

  localparam int unsigned AW = 2;

`ifdef FIFO_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          push;
  logic [AW:0]   rptr;
  logic          wr_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr_gray;
  logic          full;
  logic          almost_full;
  logic          overflow;

  typedef struct packed {
    logic [AW:0]   gray;
    logic [AW-1:0] waddr;
    logic          full;
    logic          ovf;
    logic          af;
  } exp_t;

  exp_t        sb[$];
  int          ncmp  = 0;
  int          nfail = 0;
  logic [AW:0] gtab[8];
  logic [AW:0] prev_gray;

  always #5 clk = ~clk;

  fifo_wptr_ctrl #(
    .ADDR_W   (AW),
    .AF_LEVEL (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .push            (push),
    .rptr_gray_async (rptr),
    .wr_en           (wr_en),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .almost_full     (almost_full),
    .overflow        (overflow)
  );

  function automatic exp_t mk(input logic [AW:0] g, input logic [AW-1:0] a,
                              input logic f, input logic o, input logic af);
    exp_t e;
    e.gray  = g;
    e.waddr = a;
    e.full  = f;
    e.ovf   = o;
    e.af    = af & AF_ON;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, check combinational wr_en, then score registered outputs.
  task automatic step(input string tag, input logic p, input logic r_rst,
                      input logic [AW:0] r, input logic exp_wr, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst  = r_rst;
    push = p;
    rptr = r;
    #1;
    chk({tag, ".wr_en"}, 8'(wr_en), 8'(exp_wr));
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".wptr_gray"},   8'(wptr_gray),   8'(got.gray));
    chk({tag, ".waddr"},       8'(waddr),       8'(got.waddr));
    chk({tag, ".full"},        8'(full),        8'(got.full));
    chk({tag, ".overflow"},    8'(overflow),    8'(got.ovf));
    chk({tag, ".almost_full"}, 8'(almost_full), 8'(got.af));
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    rptr = '0;
    gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
    gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;

    // Reset, including a push held during reset
    step("rst0", 1'b0, 1'b1, 3'b000, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0));
    step("rst1", 1'b1, 1'b1, 3'b000, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0));

    // Fill to full with the read pointer parked at 000
    step("fill1", 1'b1, 1'b0, 3'b000, 1'b1, mk(3'b001, 2'd1, 1'b0, 1'b0, 1'b0));
    step("fill2", 1'b1, 1'b0, 3'b000, 1'b1, mk(3'b011, 2'd2, 1'b0, 1'b0, 1'b1));
    step("fill3", 1'b1, 1'b0, 3'b000, 1'b1, mk(3'b010, 2'd3, 1'b0, 1'b0, 1'b1));
    step("fill4", 1'b1, 1'b0, 3'b000, 1'b1, mk(3'b110, 2'd0, 1'b1, 1'b0, 1'b1));

    // Push while full, then one idle cycle for the overflow pulse to drop
    step("ovf",   1'b1, 1'b0, 3'b000, 1'b0, mk(3'b110, 2'd0, 1'b1, 1'b1, 1'b1));
    step("idle",  1'b0, 1'b0, 3'b000, 1'b0, mk(3'b110, 2'd0, 1'b1, 1'b0, 1'b1));

    // Read pointer advances by one: full clears on the 3rd edge
    step("drain1", 1'b0, 1'b0, 3'b001, 1'b0, mk(3'b110, 2'd0, 1'b1, 1'b0, 1'b1));
    step("drain2", 1'b0, 1'b0, 3'b001, 1'b0, mk(3'b110, 2'd0, 1'b1, 1'b0, 1'b1));
    step("drain3", 1'b0, 1'b0, 3'b001, 1'b0, mk(3'b110, 2'd0, 1'b0, 1'b0, 1'b1));

    // Reset mid-operation discards pointer state
    step("midrst", 1'b1, 1'b1, 3'b000, 1'b0, mk(3'b000, 2'd0, 1'b0, 1'b0, 1'b0));

    // Wrap-around with the read pointer one entry behind
    prev_gray = wptr_gray;
    for (int k = 0; k < 8; k++) begin
      step($sformatf("wrap%0d.a", k), 1'b1, 1'b0, gtab[k], 1'b1,
           mk(gtab[(k + 1) % 8], 2'((k + 1) % 4), 1'b0, 1'b0, k >= 1));
      chk($sformatf("wrap%0d.onebit", k), 8'($countones(prev_gray ^ wptr_gray) == 1), 8'd1);
      prev_gray = wptr_gray;
      step($sformatf("wrap%0d.b", k), 1'b0, 1'b0, gtab[k], 1'b0,
           mk(gtab[(k + 1) % 8], 2'((k + 1) % 4), 1'b0, 1'b0, k >= 1));
      step($sformatf("wrap%0d.c", k), 1'b0, 1'b0, gtab[k], 1'b0,
           mk(gtab[(k + 1) % 8], 2'((k + 1) % 4), 1'b0, 1'b0, 1'b0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fifo_wptr_ctrl.md
FIFO_WPTR_CTRL -- requirements
Module: fifo_wptr_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4, RAM address width; FIFO depth is 2**ADDR_W.
REQ-002 Parameter AF_LEVEL, default 2**ADDR_W-2, occupancy at or above which almost_full asserts.
REQ-003 clk  input  1  sole clock; all flops rise-edge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 push  input  1  write request from producer.
REQ-006 rptr_gray_async  input  ADDR_W+1  gray read pointer from the read domain; asynchronous to clk.
REQ-007 wr_en  output  1  RAM write enable, equal to push AND NOT full, combinational.
REQ-008 waddr  output  ADDR_W  RAM write address, equal to the low ADDR_W bits of the binary write pointer.
REQ-009 wptr_gray  output  ADDR_W+1  registered gray write pointer, sent to the read domain.
REQ-010 full  output  1  registered full flag.
REQ-011 almost_full  output  1  registered almost-full flag.
REQ-012 overflow  output  1  registered one-cycle pulse, push seen while full.

Function
REQ-013 The binary write pointer wbin is ADDR_W+1 bits wide and SHALL increment by 1 on each cycle wr_en=1, wrapping from 2**(ADDR_W+1)-1 to 0.
REQ-014 wbin_next SHALL be wbin+wr_en, and gray_next SHALL be wbin_next XOR (wbin_next>>1).
REQ-015 wptr_gray SHALL load gray_next every cycle, so it changes on the same edge as wbin and differs from its previous value by exactly one bit.
REQ-016 rptr_gray_async SHALL pass through a 2-flop synchronizer (rq1, rq2); no other logic reads it.
REQ-017 full SHALL load (gray_next == {~rq2[ADDR_W:ADDR_W-1], rq2[ADDR_W-2:0]}); the push that fills the FIFO asserts full on the same edge it is written.
REQ-018 A read-pointer change SHALL clear full no earlier than the 3rd rising edge after rptr_gray_async changes (2 sync edges + 1 flag edge); full is pessimistic, never optimistic.
REQ-019 Push while full: wr_en=0, wbin and wptr_gray hold, and overflow=1 for the next cycle only.
REQ-020 A push and a remote pointer change in the same cycle SHALL be evaluated against the current rq2 only.
REQ-021 overflow SHALL be 0 in every cycle that does not follow a push-while-full cycle.

Reset
REQ-022 On rst=1 at a rising edge: wbin, wptr_gray, rq1, rq2, full, almost_full and overflow SHALL all be 0.
REQ-023 Reset mid-operation SHALL discard pointer state immediately; wr_en SHALL be 0 while rst=1.

Configuration
REQ-024 Macro FIFO_ALMOST_FULL_EN defined: rq2 is converted gray-to-binary (rbin), and almost_full loads ((wbin_next - rbin) mod 2**(ADDR_W+1)) >= AF_LEVEL.
REQ-025 Macro FIFO_ALMOST_FULL_EN not defined: almost_full is tied to 0, the port is kept, and no gray-to-binary or subtractor logic is built.

Structure
REQ-026 The shared package fifo_pkg SHALL hold SYNC_STAGES=2, default ADDR_W=4, and the gray-to-binary function.
REQ-027 The local constant PTR_W=ADDR_W+1 SHALL live in the module.
REQ-028 The module SHALL contain exactly one sub-module, bin_to_gray (WIDTH=PTR_W), which produces gray_next; no other hierarchy.

Verification
REQ-029 Reset check, ADDR_W=2: assert rst for 2 cycles -> all outputs 0, waddr=0.
REQ-030 Fill, ADDR_W=2, rptr_gray_async=000: 4 pushes -> wptr_gray 001,011,010,110, waddr 1,2,3,0, full=1 on the 4th push edge.
REQ-031 Overflow: while full, push for 1 cycle -> wr_en=0, wptr_gray stays 110, overflow=1 for exactly 1 cycle.
REQ-032 Drain, from full: set rptr_gray_async=001 -> full stays 1 for 2 edges and reads 0 after the 3rd edge.
REQ-033 Wrap-around: 8 pushes, with rptr tracking 1 entry behind -> wptr_gray goes 100 -> 000 at binary 7->0, full never asserts, and no two consecutive wptr_gray values differ by more than 1 bit.
REQ-034 Almost-full (macro defined, AF_LEVEL=2), ADDR_W=2, rptr=000: 2nd push -> almost_full=1; with the macro undefined, the same stimulus keeps almost_full=0.
